// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle.
// Carries the instruction-memory request/response channel, the decode stall,
// the EX redirect, and the IF/ID register outputs.
interface fetch_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_stall;
    logic        ex_branch_taken;
    logic [63:0] ex_branch_target;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_misaligned;

    // Fetch controller side
    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_misaligned,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_stall,
               ex_branch_taken, ex_branch_target
    );

    // Memory / pipeline side
    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_misaligned,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_stall,
               ex_branch_taken, ex_branch_target
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one outstanding imem
// request at a time, handles decode stalls via a one-entry skid register and
// EX redirects via a kill flag that discards the in-flight response.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic        kill_q, kill_d;
    logic        req_en_q;
    logic [63:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic        if_valid_q, if_valid_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        misaligned_q, misaligned_d;
    logic        loaded;
    logic        req_hs;

    // Requests are held off until the first edge after reset releases.
    assign bus.imem_req_valid   = req_en_q && (state_q == StReq);
    assign bus.imem_req_addr    = pc_q;
    assign bus.if_valid         = if_valid_q;
    assign bus.if_pc            = if_pc_q;
    assign bus.if_instr         = if_instr_q;
    assign bus.fetch_misaligned = misaligned_q;
    assign req_hs               = bus.imem_req_valid && bus.imem_req_ready;

    // State, PC and IF/ID register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StReq;
            kill_q       <= 1'b0;
            req_en_q     <= 1'b0;
            pc_q         <= RESET_PC;
            skid_q       <= NOP_INSTR;
            if_valid_q   <= 1'b0;
            if_pc_q      <= RESET_PC;
            if_instr_q   <= NOP_INSTR;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            req_en_q     <= 1'b1;
            pc_q         <= pc_d;
            skid_q       <= skid_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state: redirect wins over response and stall.
    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        pc_d         = pc_q;
        skid_d       = skid_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        misaligned_d = 1'b0;
        loaded       = 1'b0;

        if (bus.ex_branch_taken) begin
            pc_d         = {bus.ex_branch_target[63:2], 2'b00};
            if_valid_d   = 1'b0;
            if_instr_d   = NOP_INSTR;
            misaligned_d = |bus.ex_branch_target[1:0];
            case (state_q)
                StReq: begin
                    // Request accepted at the old PC: its response must be discarded.
                    if (req_hs) begin
                        state_d = StWait;
                        kill_d  = 1'b1;
                    end
                end
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        state_d = StReq;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: state_d = StReq;
            endcase
        end else begin
            case (state_q)
                StReq: begin
                    if (req_hs) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = StReq;
                        end else if (!bus.id_stall || !if_valid_q) begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_instr_d = bus.imem_rsp_data;
                            pc_d       = pc_q + 64'd4;
                            state_d    = StReq;
                            loaded     = 1'b1;
                        end else begin
                            skid_d  = bus.imem_rsp_data;
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    // PC still points at the skid instruction.
                    if (!bus.id_stall) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = skid_q;
                        pc_d       = pc_q + 64'd4;
                        state_d    = StReq;
                        loaded     = 1'b1;
                    end
                end
                default: state_d = StReq;
            endcase
            // Decode consumed the current entry and nothing replaces it.
            if (!loaded && !bus.id_stall) begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by a randomized run
// checked against a program-order model of fetch and decode.
module tb_fetch_ctrl;

    localparam logic [63:0] RESET_PC  = 64'h0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] BAD       = 32'hDEAD_BEEF;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_req_valid"}, bus.imem_req_valid, 1'b0);
        chk1({tag, "_if_valid"}, bus.if_valid, 1'b0);
        chk({tag, "_if_pc"}, bus.if_pc, RESET_PC);
        chk32({tag, "_if_instr"}, bus.if_instr, NOP_INSTR);
        chk1({tag, "_misaligned"}, bus.fetch_misaligned, 1'b0);
    endtask

    // Instruction memory contents: top byte never matches the NOP encoding.
    function automatic logic [31:0] memf(input logic [63:0] a);
        return {8'hC3, a[25:2]};
    endfunction

    // Randomized-phase model state
    logic [63:0] exp_fetch;
    logic [63:0] exp_dec;
    logic [63:0] mem_addr;
    logic [63:0] hs_addr;
    logic        mem_busy;
    logic        hs;
    logic        prev_mis;
    logic        rsp_now;
    int          mem_cnt;
    int          consumed;
    int          handshakes;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.imem_req_ready   = 1'b0;
        bus.imem_rsp_valid   = 1'b0;
        bus.imem_rsp_data    = 32'h0;
        bus.id_stall         = 1'b0;
        bus.ex_branch_taken  = 1'b0;
        bus.ex_branch_target = 64'h0;
        cyc();
        cyc();
        chk_reset_vals("reset");

        // Release reset: no request until the next edge.
        rst = 1'b0;
        #1;
        chk1("no_req_before_edge", bus.imem_req_valid, 1'b0);
        cyc();
        chk1("first_req_valid", bus.imem_req_valid, 1'b1);
        chk("first_req_addr", bus.imem_req_addr, 64'h0);

        // 1-cycle memory, no stalls
        bus.imem_req_ready = 1'b1;
        cyc();
        chk1("wait_no_req", bus.imem_req_valid, 1'b0);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h1111_0001;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk1("d0_valid", bus.if_valid, 1'b1);
        chk32("d0_instr", bus.if_instr, 32'h1111_0001);
        chk("d0_pc", bus.if_pc, 64'h0);
        chk("req_addr_4", bus.imem_req_addr, 64'h4);
        chk1("req_valid_4", bus.imem_req_valid, 1'b1);
        bus.imem_req_ready = 1'b1;
        cyc();
        chk1("bubble_valid", bus.if_valid, 1'b0);
        chk32("bubble_instr", bus.if_instr, NOP_INSTR);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h2222_0002;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk1("d1_valid", bus.if_valid, 1'b1);
        chk32("d1_instr", bus.if_instr, 32'h2222_0002);
        chk("d1_pc", bus.if_pc, 64'h4);
        chk("req_addr_8", bus.imem_req_addr, 64'h8);

        // Response under stall goes to the skid register
        bus.id_stall       = 1'b1;
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        chk1("stall_hold_valid", bus.if_valid, 1'b1);
        chk32("stall_hold_instr", bus.if_instr, 32'h2222_0002);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h3333_0003;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk1("hold_no_req", bus.imem_req_valid, 1'b0);
        chk32("hold_if_instr", bus.if_instr, 32'h2222_0002);
        cyc();
        chk1("hold_no_req2", bus.imem_req_valid, 1'b0);
        bus.id_stall = 1'b0;
        cyc();
        chk32("skid_instr", bus.if_instr, 32'h3333_0003);
        chk("skid_pc", bus.if_pc, 64'h8);
        chk1("after_hold_req", bus.imem_req_valid, 1'b1);
        chk("after_hold_addr", bus.imem_req_addr, 64'hC);

        // Redirect while waiting; the late response is dropped
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready   = 1'b0;
        bus.ex_branch_taken  = 1'b1;
        bus.ex_branch_target = 64'h1000;
        cyc();
        bus.ex_branch_taken = 1'b0;
        chk1("br_wait_no_req", bus.imem_req_valid, 1'b0);
        chk1("br_wait_flush", bus.if_valid, 1'b0);
        cyc();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = BAD;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk1("killed_valid", bus.if_valid, 1'b0);
        chk32("killed_instr", bus.if_instr, NOP_INSTR);
        chk1("killed_req", bus.imem_req_valid, 1'b1);
        chk("killed_addr", bus.imem_req_addr, 64'h1000);
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h4444_0004;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk32("target_instr", bus.if_instr, 32'h4444_0004);
        chk("target_pc", bus.if_pc, 64'h1000);
        chk("target_next_addr", bus.imem_req_addr, 64'h1004);

        // Redirect in the same cycle as the response
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready   = 1'b0;
        bus.imem_rsp_valid   = 1'b1;
        bus.imem_rsp_data    = BAD;
        bus.ex_branch_taken  = 1'b1;
        bus.ex_branch_target = 64'h2000;
        cyc();
        bus.imem_rsp_valid  = 1'b0;
        bus.ex_branch_taken = 1'b0;
        chk1("br_rsp_valid", bus.if_valid, 1'b0);
        chk1("br_rsp_req", bus.imem_req_valid, 1'b1);
        chk("br_rsp_addr", bus.imem_req_addr, 64'h2000);

        // Redirect in REQ without acceptance
        bus.ex_branch_taken  = 1'b1;
        bus.ex_branch_target = 64'h3000;
        cyc();
        bus.ex_branch_taken = 1'b0;
        chk1("br_req_valid", bus.imem_req_valid, 1'b1);
        chk("br_req_addr", bus.imem_req_addr, 64'h3000);
        chk1("br_req_aligned", bus.fetch_misaligned, 1'b0);

        // Misaligned target
        bus.ex_branch_taken  = 1'b1;
        bus.ex_branch_target = 64'h1002;
        cyc();
        bus.ex_branch_taken = 1'b0;
        chk("mis_addr", bus.imem_req_addr, 64'h1000);
        chk1("mis_pulse", bus.fetch_misaligned, 1'b1);
        cyc();
        chk1("mis_pulse_end", bus.fetch_misaligned, 1'b0);

        // PC wraps at the top of the address space
        bus.ex_branch_taken  = 1'b1;
        bus.ex_branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        bus.ex_branch_taken = 1'b0;
        bus.imem_req_ready  = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h5555_0005;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk("wrap_if_pc", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk32("wrap_instr", bus.if_instr, 32'h5555_0005);
        chk("wrap_addr", bus.imem_req_addr, 64'h0);

        // Reset while waiting, then a stray response
        bus.id_stall       = 1'b1;
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        chk1("pre_rst_valid", bus.if_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        cyc();
        rst                = 1'b0;
        bus.id_stall       = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = BAD;
        #1;
        chk1("rst_gap_no_req", bus.imem_req_valid, 1'b0);
        cyc();
        chk1("stray_req", bus.imem_req_valid, 1'b1);
        chk("stray_addr", bus.imem_req_addr, RESET_PC);
        chk1("stray_valid", bus.if_valid, 1'b0);
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk1("stray_valid2", bus.if_valid, 1'b0);
        chk32("stray_instr", bus.if_instr, NOP_INSTR);
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h6666_0006;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk("restart_pc", bus.if_pc, RESET_PC);
        chk32("restart_instr", bus.if_instr, 32'h6666_0006);

        // Randomized run against the program-order model
        rst = 1'b1;
        cyc();
        rst        = 1'b0;
        exp_fetch  = RESET_PC;
        exp_dec    = RESET_PC;
        mem_busy   = 1'b0;
        mem_addr   = 64'h0;
        mem_cnt    = 0;
        prev_mis   = 1'b0;
        consumed   = 0;
        handshakes = 0;
        for (int n = 0; n < 3000; n++) begin
            bus.imem_req_ready  = ($urandom_range(0, 9) < 6);
            bus.id_stall        = ($urandom_range(0, 9) < 3);
            bus.ex_branch_taken = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.ex_branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            end else begin
                bus.ex_branch_target = 64'($urandom_range(0, 65535));
            end
            rsp_now = mem_busy && (mem_cnt == 0);
            if (rsp_now) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = memf(mem_addr);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
                if (mem_busy) mem_cnt--;
            end
            #1;
            hs      = bus.imem_req_valid && bus.imem_req_ready;
            hs_addr = bus.imem_req_addr;

            chk1("rnd_misaligned", bus.fetch_misaligned, prev_mis);
            if (!bus.if_valid) chk32("rnd_bubble_nop", bus.if_instr, NOP_INSTR);
            if (hs) begin
                handshakes++;
                chk1("rnd_single_outstanding", mem_busy, 1'b0);
                chk("rnd_fetch_addr", hs_addr, exp_fetch);
            end
            if (bus.ex_branch_taken) begin
                exp_dec   = {bus.ex_branch_target[63:2], 2'b00};
                exp_fetch = {bus.ex_branch_target[63:2], 2'b00};
            end else begin
                if (hs) exp_fetch = exp_fetch + 64'd4;
                if (bus.if_valid && !bus.id_stall) begin
                    consumed++;
                    chk("rnd_dec_pc", bus.if_pc, exp_dec);
                    chk32("rnd_dec_instr", bus.if_instr, memf(exp_dec));
                    exp_dec = exp_dec + 64'd4;
                end
            end
            prev_mis = bus.ex_branch_taken && (bus.ex_branch_target[1:0] != 2'b00);

            if (rsp_now) mem_busy = 1'b0;
            if (hs) begin
                mem_busy = 1'b1;
                mem_addr = hs_addr;
                mem_cnt  = int'($urandom_range(0, 2));
            end
            cyc();
        end
        chk1("rnd_progress_dec", consumed >= 50, 1'b1);
        chk1("rnd_progress_fetch", handshakes >= 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the RV64 five-stage pipeline. It owns the program counter and sequences single-outstanding requests to the instruction memory. It applies decode stalls and execute-stage branch redirects, discarding in-flight fetches on redirect, and drives the IF/ID pipeline register with a valid instruction or a NOP bubble.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- NOP_INSTR, 32'h00000013, bubble encoding (ADDI x0, x0, 0)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request; handshake = valid && ready
- imem_req_addr  out  64  fetch address (= pc)
- imem_rsp_valid  in  1  response strobe, at least 1 cycle after its handshake
- imem_rsp_data  in  32  fetched instruction
- id_stall  in  1  decode cannot accept a new instruction
- ex_branch_taken  in  1  redirect pulse from EX
- ex_branch_target  in  64  redirect address
- if_valid  out  1  IF/ID register holds a real instruction
- if_pc  out  64  PC of if_instr
- if_instr  out  32  instruction to decode
- fetch_misaligned  out  1  1-cycle pulse: target[1:0] != 0

## Operation
- States: REQ, WAIT, HOLD. The kill flag is separate from the state.
- REQ
  - imem_req_valid = 1, addr = pc.
  - On handshake, go to WAIT.
  - Before acceptance, addr may change, but only through a redirect. Memory samples only on handshake.
- WAIT
  - imem_req_valid = 0.
  - On imem_rsp_valid with kill = 0:
    - If id_stall = 0 or if_valid = 0: load if_instr = data, if_pc = pc, if_valid = 1; pc += 4; go to REQ.
    - Otherwise: store data in the skid register; go to HOLD.
  - On imem_rsp_valid with kill = 1: drop the data, clear kill, go to REQ (pc already equals the target).
- HOLD
  - No request.
  - When id_stall = 0: skid moves to the IF/ID register; pc += 4; go to REQ.
- IF/ID register rule: when id_stall = 0 and no new instruction is loaded, if_valid <= 0 and if_instr <= NOP_INSTR. When id_stall = 1, the IF/ID register holds.
- Redirect (ex_branch_taken = 1) has priority over stall and response.
  - pc <= {target[63:2], 2'b00}.
  - if_valid <= 0, if_instr <= NOP_INSTR. This flushes even under id_stall.
  - Skid register is discarded.
  - From REQ without handshake: stay in REQ at the new address.
  - From REQ with a handshake the same cycle: go to WAIT with kill = 1.
  - From WAIT with no response that cycle: stay in WAIT, kill = 1.
  - From WAIT with a response the same cycle: drop the response, go to REQ.
  - From HOLD: go to REQ.
- fetch_misaligned pulses in the cycle after a redirect whose target[1:0] != 0.
- PC arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values, applied immediately:
  - pc = RESET_PC, state = REQ, kill = 0
  - imem_req_valid = 0
  - if_valid = 0, if_pc = RESET_PC, if_instr = NOP_INSTR
  - fetch_misaligned = 0
- imem_req_valid first rises on the first clk edge after rst deasserts.
- Best-case throughput: 1 instruction per 2 cycles with a 1-cycle memory (REQ, then WAIT/response).
- Redirect latency: the request to the target is presented the cycle after ex_branch_taken.
- Reset mid-operation aborts everything. Any response arriving after reset deasserts with no handshake since is ignored (kill is forced to 0 and state is REQ). Memory is reset together with this block.

## Test plan
- Reset, then 1-cycle memory, no stalls:
  - imem_req_addr sequence 0x0, 0x4, 0x8.
  - if_instr follows the responses; if_valid alternates 1/0.
  - if_pc matches the fetch address.
- Response arrives while id_stall = 1 and if_valid = 1:
  - Enters HOLD; no request while stalled.
  - On stall release, if_instr = skid data and if_pc = stalled PC + 4.
  - The next request goes out one cycle later.
- Branch to 0x1000 while in WAIT (response 2 cycles later):
  - That response is dropped; if_valid stays 0.
  - Next request addr = 0x1000; decode never sees the wrong-path instruction.
- Branch in the same cycle as imem_rsp_valid, and branch during REQ with imem_req_ready = 0:
  - Response is dropped.
  - imem_req_addr switches to the target without an intervening handshake.
- Branch to 0x1002:
  - Fetch addr = 0x1000.
  - fetch_misaligned = 1 for exactly one cycle.
- rst asserted while in WAIT:
  - All outputs take reset values immediately.
  - A subsequent stray imem_rsp_valid is ignored.
  - Fetch restarts at RESET_PC.
